vend_credit_fsm: RTL and testbench

//  Parametrised vending controller with credit accumulation, vend handshake and change return.

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_credit_fsm_if.sv | 27 ++
 rtl/vend_coin_decode.sv | 14 +
 rtl/vend_credit_fsm.sv | 118 +++++++++++
 tb/tb_vend_credit_fsm.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vending credit controller: FSM states and coin codes.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    // Credit units carried by each coin code; one unit is worth 5.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 3'd1;
            COIN_10: return 3'd2;
            COIN_25: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_credit_fsm_if.sv
// Bundle between the coin front-end / actuators (master) and the controller (slave).
// Latency: n/a (wires only).
// Backpressure: vend_ready and change_ready throttle the controller's valids.
interface vend_credit_fsm_if #(
    parameter int CREDIT_W = 6
) ();
    logic                coin_valid;
    logic [1:0]          coin;
    logic                cancel;
    logic                vend_valid;
    logic                vend_ready;
    logic                change_valid;
    logic                change_ready;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                busy;

    modport master (
        output coin_valid, coin, cancel, vend_ready, change_ready,
        input  vend_valid, change_valid, credit, coin_reject, busy
    );

    modport slave (
        input  coin_valid, coin, cancel, vend_ready, change_ready,
        output vend_valid, change_valid, credit, coin_reject, busy
    );
endinterface

// File: rtl/vend_coin_decode.sv
// Maps a raw coin code to its credit value and flags whether it is a real coin.
// Latency: combinational.
// Backpressure: none.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic       coin_valid,
    input  logic [1:0] coin,
    output logic [2:0] val,
    output logic       legal
);
    assign val   = coin_value(coin);
    assign legal = coin_valid && (coin != COIN_NONE);
endmodule

// File: rtl/vend_credit_fsm.sv
// Vending controller: accumulates coin credit, requests one vend at PRICE, then pays change one unit at a time.
// Latency: one cycle from coin/cancel/handshake to every registered output.
// Backpressure: vend_valid / change_valid hold (credit frozen) until the matching ready is sampled high.
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 20,
    parameter int CREDIT_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    vend_credit_fsm_if.slave   bus
);
    localparam logic [CREDIT_W:0] PRICE_SUM = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] MAX_SUM   = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_valid_q, vend_valid_d;
    logic                change_valid_q, change_valid_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;

    logic [2:0]          coin_val;
    logic                coin_legal;
    logic [CREDIT_W:0]   sum;

    vend_coin_decode u_decode (
        .coin_valid (bus.coin_valid),
        .coin       (bus.coin),
        .val        (coin_val),
        .legal      (coin_legal)
    );

    // One spare bit so an overflowing coin is detected rather than wrapped.
    assign sum = {1'b0, credit_q} + {{(CREDIT_W-2){1'b0}}, coin_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            vend_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_valid_q   <= vend_valid_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (bus.cancel && state_q == COLLECT) begin
                    // Cancel wins over a coin arriving in the same cycle.
                    state_d       = CHANGE;
                    coin_reject_d = bus.coin_valid;
                end else if (bus.coin_valid) begin
                    if (coin_legal && !bus.cancel && sum <= MAX_SUM) begin
                        if (sum >= PRICE_SUM) begin
                            state_d  = VEND;
                            credit_d = CREDIT_W'(sum - PRICE_SUM);
                        end else begin
                            state_d  = COLLECT;
                            credit_d = CREDIT_W'(sum);
                        end
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_reject_d = bus.coin_valid;
                if (bus.vend_ready) begin
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = bus.coin_valid;
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (bus.change_ready) begin
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Flags follow the next state so they line up with the state register.
    always_comb begin
        vend_valid_d   = (state_d == VEND);
        change_valid_d = (state_d == CHANGE);
        busy_d         = (state_d == VEND) || (state_d == CHANGE);
    end

    assign bus.vend_valid   = vend_valid_q;
    assign bus.change_valid = change_valid_q;
    assign bus.credit       = credit_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Scoreboarded directed test of vend_credit_fsm: default instance plus a PRICE=20 instance for overflow.
module tb_vend_credit_fsm;
    import vend_pkg::*;

    typedef struct {
        bit         sel;
        logic [9:0] exp_vec;
        string      name;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   n_checks;
    int   n_pass;
    bit   drained;

    vend_credit_fsm_if #(.CREDIT_W(6)) bus_a ();
    vend_credit_fsm_if #(.CREDIT_W(6)) bus_b ();

    vend_credit_fsm #(.PRICE(3), .MAX_CREDIT(20), .CREDIT_W(6)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    vend_credit_fsm #(.PRICE(20), .MAX_CREDIT(20), .CREDIT_W(6)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the selected instance (the other idles) and queue the
    // outputs expected after the coming edge: {credit, vend_valid, change_valid, coin_reject, busy}.
    task automatic step(input bit sel, input bit rst, input bit cv, input logic [1:0] cn,
                        input bit can, input bit vr, input bit cr,
                        input int e_credit, input bit e_vv, input bit e_cv,
                        input bit e_rej, input bit e_busy, input string name);
        exp_t e;
        @(negedge clk);
        #1;
        reset              = rst;
        bus_a.coin_valid   = (sel == 1'b0) ? cv  : 1'b0;
        bus_a.coin         = (sel == 1'b0) ? cn  : 2'b00;
        bus_a.cancel       = (sel == 1'b0) ? can : 1'b0;
        bus_a.vend_ready   = (sel == 1'b0) ? vr  : 1'b0;
        bus_a.change_ready = (sel == 1'b0) ? cr  : 1'b0;
        bus_b.coin_valid   = (sel == 1'b1) ? cv  : 1'b0;
        bus_b.coin         = (sel == 1'b1) ? cn  : 2'b00;
        bus_b.cancel       = (sel == 1'b1) ? can : 1'b0;
        bus_b.vend_ready   = (sel == 1'b1) ? vr  : 1'b0;
        bus_b.change_ready = (sel == 1'b1) ? cr  : 1'b0;
        e.sel     = sel;
        e.exp_vec = {6'(e_credit), e_vv, e_cv, e_rej, e_busy};
        e.name    = name;
        sb.push_back(e);
        if (rst) begin
            e.sel  = ~sel;
            e.name = {name, "_other"};
            sb.push_back(e);
        end
    endtask

    // Everything queued was pushed just after the previous falling edge, so it
    // describes the outputs now settled after the rising edge in between.
    initial begin
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = e.sel ? {bus_b.credit, bus_b.vend_valid, bus_b.change_valid, bus_b.coin_reject, bus_b.busy}
                            : {bus_a.credit, bus_a.vend_valid, bus_a.change_valid, bus_a.coin_reject, bus_a.busy};
                n_checks++;
                if (act === e.exp_vec) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got credit=%0d vv=%b cv=%b rej=%b busy=%b, want credit=%0d vv=%b cv=%b rej=%b busy=%b",
                             e.name, act[9:4], act[3], act[2], act[1], act[0],
                             e.exp_vec[9:4], e.exp_vec[3], e.exp_vec[2], e.exp_vec[1], e.exp_vec[0]);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        drained  = 1'b0;
        reset    = 1'b1;
        bus_a.coin_valid = 1'b0; bus_a.coin = 2'b00; bus_a.cancel = 1'b0;
        bus_a.vend_ready = 1'b0; bus_a.change_ready = 1'b0;
        bus_b.coin_valid = 1'b0; bus_b.coin = 2'b00; bus_b.cancel = 1'b0;
        bus_b.vend_ready = 1'b0; bus_b.change_ready = 1'b0;

        //   sel rst cv coin   can vr cr   credit vv cv rej busy
        step(0, 1, 0, 2'b00, 0, 0, 0,    0,   0, 0, 0, 0, "reset");

        @(posedge clk);
        #1;
        n_checks++;
        if ({bus_a.credit, bus_a.vend_valid, bus_a.change_valid, bus_a.coin_reject, bus_a.busy} !== 10'd0) begin
            $display("FAIL reset_state_a: credit=%0d vv=%b cv=%b rej=%b busy=%b",
                     bus_a.credit, bus_a.vend_valid, bus_a.change_valid, bus_a.coin_reject, bus_a.busy);
        end else begin
            n_pass++;
        end
        n_checks++;
        if ({bus_b.credit, bus_b.vend_valid, bus_b.change_valid, bus_b.coin_reject, bus_b.busy} !== 10'd0) begin
            $display("FAIL reset_state_b: credit=%0d vv=%b cv=%b rej=%b busy=%b",
                     bus_b.credit, bus_b.vend_valid, bus_b.change_valid, bus_b.coin_reject, bus_b.busy);
        end else begin
            n_pass++;
        end

        // Exact price with a stalled dispenser.
        step(0, 0, 1, 2'b01, 0, 0, 0,    1,   0, 0, 0, 0, "t1_coin1");
        step(0, 0, 1, 2'b01, 0, 0, 0,    2,   0, 0, 0, 0, "t1_coin2");
        step(0, 0, 1, 2'b01, 0, 0, 0,    0,   1, 0, 0, 1, "t1_coin3_vend");
        step(0, 0, 0, 2'b00, 0, 0, 0,    0,   1, 0, 0, 1, "t1_vend_hold");
        step(0, 0, 0, 2'b00, 0, 1, 0,    0,   0, 0, 0, 0, "t1_vend_hs_idle");
        step(0, 0, 0, 2'b00, 0, 0, 0,    0,   0, 0, 0, 0, "t1_idle_stays");

        // Change after vend.
        step(0, 0, 1, 2'b11, 0, 0, 0,    2,   1, 0, 0, 1, "t2_coin25");
        step(0, 0, 0, 2'b00, 0, 1, 0,    2,   0, 1, 0, 1, "t2_to_change");
        step(0, 0, 0, 2'b00, 0, 0, 1,    1,   0, 1, 0, 1, "t2_change1");
        step(0, 0, 0, 2'b00, 0, 0, 1,    0,   0, 0, 0, 0, "t2_change2_idle");

        // Refund under changer backpressure.
        step(0, 0, 1, 2'b10, 0, 0, 0,    2,   0, 0, 0, 0, "t3_coin10");
        step(0, 0, 0, 2'b00, 1, 0, 0,    2,   0, 1, 0, 1, "t3_cancel");
        step(0, 0, 0, 2'b00, 0, 0, 0,    2,   0, 1, 0, 1, "t3_bp1");
        step(0, 0, 0, 2'b00, 0, 0, 0,    2,   0, 1, 0, 1, "t3_bp2");
        step(0, 0, 0, 2'b00, 0, 0, 0,    2,   0, 1, 0, 1, "t3_bp3");
        step(0, 0, 0, 2'b00, 0, 0, 1,    1,   0, 1, 0, 1, "t3_refund1");
        step(0, 0, 0, 2'b00, 0, 0, 1,    0,   0, 0, 0, 0, "t3_refund2_idle");

        // Collisions: coins during VEND and CHANGE, coin with cancel, null coin, idle cancel.
        step(0, 0, 1, 2'b11, 0, 0, 0,    2,   1, 0, 0, 1, "t5_coin25");
        step(0, 0, 1, 2'b10, 0, 0, 0,    2,   1, 0, 1, 1, "t5_coin_in_vend");
        step(0, 0, 0, 2'b00, 0, 1, 0,    2,   0, 1, 0, 1, "t5_to_change");
        step(0, 0, 1, 2'b01, 0, 0, 0,    2,   0, 1, 1, 1, "t5_coin_in_change");
        step(0, 0, 0, 2'b00, 0, 0, 1,    1,   0, 1, 0, 1, "t5_change1");
        step(0, 0, 0, 2'b00, 0, 0, 1,    0,   0, 0, 0, 0, "t5_change2_idle");
        step(0, 0, 1, 2'b01, 0, 0, 0,    1,   0, 0, 0, 0, "t5_coin1");
        step(0, 0, 1, 2'b10, 1, 0, 0,    1,   0, 1, 1, 1, "t5_coin_cancel");
        step(0, 0, 0, 2'b00, 0, 0, 1,    0,   0, 0, 0, 0, "t5_refund_idle");
        step(0, 0, 1, 2'b00, 0, 0, 0,    0,   0, 0, 1, 0, "t5_null_coin");
        step(0, 0, 0, 2'b00, 0, 0, 0,    0,   0, 0, 0, 0, "t5_reject_pulse_end");
        step(0, 0, 0, 2'b00, 1, 0, 0,    0,   0, 0, 0, 0, "t5_cancel_idle");

        // Reset in the middle of paying change.
        step(0, 0, 1, 2'b11, 0, 0, 0,    2,   1, 0, 0, 1, "t6_coin25");
        step(0, 0, 0, 2'b00, 0, 1, 0,    2,   0, 1, 0, 1, "t6_to_change");
        step(0, 1, 0, 2'b00, 0, 0, 0,    0,   0, 0, 0, 0, "t6_reset");
        step(0, 0, 0, 2'b00, 0, 0, 0,    0,   0, 0, 0, 0, "t6_after_reset");

        // Overflow on the PRICE=20 instance.
        step(1, 0, 1, 2'b11, 0, 0, 0,    5,   0, 0, 0, 0, "t4_c5");
        step(1, 0, 1, 2'b11, 0, 0, 0,   10,   0, 0, 0, 0, "t4_c10");
        step(1, 0, 1, 2'b11, 0, 0, 0,   15,   0, 0, 0, 0, "t4_c15");
        step(1, 0, 1, 2'b10, 0, 0, 0,   17,   0, 0, 0, 0, "t4_c17");
        step(1, 0, 1, 2'b10, 0, 0, 0,   19,   0, 0, 0, 0, "t4_c19");
        step(1, 0, 1, 2'b10, 0, 0, 0,   19,   0, 0, 1, 0, "t4_overflow_reject");
        step(1, 0, 1, 2'b01, 0, 0, 0,    0,   1, 0, 0, 1, "t4_exact_max_vend");
        step(1, 0, 0, 2'b00, 0, 1, 0,    0,   0, 0, 0, 0, "t4_vend_hs_idle");

        step(0, 0, 0, 2'b00, 0, 0, 0,    0,   0, 0, 0, 0, "final_idle");

        fork
            begin
                wait (sb.size() == 0);
                drained = 1'b1;
            end
            begin
                repeat (20) @(posedge clk);
            end
        join_any
        disable fork;
        n_checks++;
        if (!drained || sb.size() != 0) begin
            $display("FAIL drain_timeout: %0d expectations never checked", sb.size());
        end else begin
            n_pass++;
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
